// File: rtl/core_sequencer_if.sv
// Run-control bundle between the debug host, the instruction decoder and core_sequencer.
// The master side drives requests and decoder strobes; the slave side returns the gated enables.
interface core_sequencer_if #(
   parameter int unsigned CNTR_WIDTH = 8,
   parameter int unsigned RET_WIDTH  = 16
);
   // Host requests
   logic                  run_req;
   logic                  halt_req;
   logic                  step_req;
   logic                  bp_en;
   logic [CNTR_WIDTH-1:0] bp_addr;
   logic [CNTR_WIDTH-1:0] pc_value;

   // Raw decoder strobes
   logic                  dec_load;
   logic                  dec_store;
   logic                  dec_jmp;
   logic                  dec_cal;
   logic                  dec_ret;

   // Gated enables and status
   logic                  ir_we;
   logic                  acc_we;
   logic                  rf_we;
   logic                  pc_en;
   logic                  jmp_en;
   logic                  cal_en;
   logic                  ret_en;
   logic                  halted;
   logic                  step_ack;
   logic                  bp_hit;
   logic [RET_WIDTH-1:0]  retired;

   modport master (
      output run_req, halt_req, step_req, bp_en, bp_addr, pc_value,
      output dec_load, dec_store, dec_jmp, dec_cal, dec_ret,
      input  ir_we, acc_we, rf_we, pc_en, jmp_en, cal_en, ret_en,
      input  halted, step_ack, bp_hit, retired
   );

   modport slave (
      input  run_req, halt_req, step_req, bp_en, bp_addr, pc_value,
      input  dec_load, dec_store, dec_jmp, dec_cal, dec_ret,
      output ir_we, acc_we, rf_we, pc_en, jmp_en, cal_en, ret_en,
      output halted, step_ack, bp_hit, retired
   );
endinterface

// File: rtl/core_sequencer.sv
// Run-control sequencer: steps each instruction through FETCH/EXEC/WB, gates decoder strobes
// into one-cycle enables, and provides halt, single-step, breakpoint and retire counting.
module core_sequencer #(
   parameter int unsigned CNTR_WIDTH    = 8,
   parameter int unsigned RET_WIDTH     = 16,
   parameter bit          START_RUNNING = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   core_sequencer_if.slave bus
);

   localparam logic [1:0] StHalt  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StExec  = 2'd2;
   localparam logic [1:0] StWb    = 2'd3;
   localparam logic [1:0] StReset = START_RUNNING ? StFetch : StHalt;

   logic [1:0]            state_q, state_d;
   logic                  run_mode_q, run_mode_d;
   logic                  halt_pend_q, halt_pend_d;
   logic                  step_mode_q, step_mode_d;
   logic                  bp_skip_q, bp_skip_d;
   logic                  bp_hit_q, bp_hit_d;
   logic                  step_ack_q, step_ack_d;
   logic [RET_WIDTH-1:0]  retired_q, retired_d;

   logic [CNTR_WIDTH-1:0] pc_w;
   logic [CNTR_WIDTH-1:0] bp_addr_w;
   logic                  bp_fire;
   logic                  wb_stop;

   logic ir_we, acc_we, rf_we, pc_en, jmp_en, cal_en, ret_en;

   assign pc_w      = bus.pc_value;
   assign bp_addr_w = bus.bp_addr;

   // bp_skip masks the first FETCH after leaving HALT so a resume at the breakpoint can't re-hit.
   assign bp_fire = (state_q == StFetch) & bus.bp_en & ~bp_skip_q & (pc_w == bp_addr_w);

   // A halt_req seen in WB itself must still stop at this boundary.
   assign wb_stop = halt_pend_q | bus.halt_req | step_mode_q | ~run_mode_q;

   always_comb begin
      state_d     = state_q;
      run_mode_d  = run_mode_q;
      halt_pend_d = halt_pend_q;
      step_mode_d = step_mode_q;
      bp_skip_d   = bp_skip_q;
      bp_hit_d    = bp_hit_q;
      step_ack_d  = 1'b0;
      retired_d   = retired_q;

      if (bus.halt_req) begin
         run_mode_d = 1'b0;
         if (state_q != StHalt) begin
            halt_pend_d = 1'b1;
         end
      end

      unique case (state_q)
         StHalt: begin
            if (bus.halt_req) begin
               state_d = StHalt;
            end else if (bus.step_req) begin
               state_d     = StFetch;
               step_mode_d = 1'b1;
               bp_skip_d   = 1'b1;
               bp_hit_d    = 1'b0;
            end else if (bus.run_req) begin
               state_d    = StFetch;
               run_mode_d = 1'b1;
               bp_skip_d  = 1'b1;
               bp_hit_d   = 1'b0;
            end
         end
         StFetch: begin
            bp_skip_d = 1'b0;
            if (bp_fire) begin
               state_d    = StHalt;
               bp_hit_d   = 1'b1;
               run_mode_d = 1'b0;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StWb;
         end
         StWb: begin
            retired_d = retired_q + RET_WIDTH'(1);
            if (wb_stop) begin
               state_d    = StHalt;
               step_ack_d = step_mode_q;
            end else begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StHalt;
         end
      endcase

      if ((state_d == StHalt) && (state_q != StHalt)) begin
         halt_pend_d = 1'b0;
         step_mode_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StReset;
         run_mode_q  <= START_RUNNING;
         halt_pend_q <= 1'b0;
         step_mode_q <= 1'b0;
         bp_skip_q   <= 1'b0;
         bp_hit_q    <= 1'b0;
         step_ack_q  <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         run_mode_q  <= run_mode_d;
         halt_pend_q <= halt_pend_d;
         step_mode_q <= step_mode_d;
         bp_skip_q   <= bp_skip_d;
         bp_hit_q    <= bp_hit_d;
         step_ack_q  <= step_ack_d;
         retired_q   <= retired_d;
      end
   end

   // Enables decode straight from state so an async reset drops them immediately.
   always_comb begin
      ir_we  = 1'b0;
      acc_we = 1'b0;
      rf_we  = 1'b0;
      pc_en  = 1'b0;
      jmp_en = 1'b0;
      cal_en = 1'b0;
      ret_en = 1'b0;
      unique case (state_q)
         StFetch: begin
            ir_we = ~bp_fire;
         end
         StExec: begin
            acc_we = bus.dec_load;
         end
         StWb: begin
            rf_we  = bus.dec_store;
            pc_en  = 1'b1;
            jmp_en = bus.dec_jmp;
            cal_en = bus.dec_cal;
            ret_en = bus.dec_ret;
         end
         default: begin
            ir_we = 1'b0;
         end
      endcase
   end

   assign bus.ir_we    = ir_we;
   assign bus.acc_we   = acc_we;
   assign bus.rf_we    = rf_we;
   assign bus.pc_en    = pc_en;
   assign bus.jmp_en   = jmp_en;
   assign bus.cal_en   = cal_en;
   assign bus.ret_en   = ret_en;
   assign bus.halted   = (state_q == StHalt);
   assign bus.step_ack = step_ack_q;
   assign bus.bp_hit   = bp_hit_q;
   assign bus.retired  = retired_q;

`ifndef SYNTHESIS
   a_halt_quiet: assert property (@(posedge clk) disable iff (rst)
      (state_q == StHalt) |-> !(ir_we | acc_we | rf_we | pc_en | jmp_en | cal_en | ret_en));
   a_ack_halted: assert property (@(posedge clk) disable iff (rst)
      step_ack_q |-> (state_q == StHalt));
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer; a tiny PC model advances on pc_en.
module tb_core_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   core_sequencer_if #(.CNTR_WIDTH(8), .RET_WIDTH(16)) bus ();

   core_sequencer #(
      .CNTR_WIDTH   (8),
      .RET_WIDTH    (16),
      .START_RUNNING(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) bus.pc_value <= 8'd0;
      else if (bus.pc_en) bus.pc_value <= bus.pc_value + 8'd1;
   end

   // {ir_we, acc_we, rf_we, pc_en, jmp_en, cal_en, ret_en}
   function automatic logic [6:0] en_vec();
      return {bus.ir_we, bus.acc_we, bus.rf_we, bus.pc_en, bus.jmp_en, bus.cal_en, bus.ret_en};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.run_req  = 1'b0;
      bus.halt_req = 1'b0;
      bus.step_req = 1'b0;
      bus.bp_en    = 1'b0;
      bus.bp_addr  = 8'd0;
      bus.dec_load = 1'b0;
      bus.dec_store = 1'b0;
      bus.dec_jmp  = 1'b0;
      bus.dec_cal  = 1'b0;
      bus.dec_ret  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (bus.halted !== 1'b1 || en_vec() !== 7'b0 || bus.retired !== 16'd0) begin
            bad++;
            $display("FAIL reset_idle[%0d]: halted=%b en=%b retired=%0d want 1/0000000/0",
                     i, bus.halted, en_vec(), bus.retired);
         end
         cyc();
      end
   endtask

   task automatic test_step();
      do_reset();
      bus.dec_load  = 1'b1;
      bus.dec_store = 1'b1;
      bus.step_req  = 1'b1;
      cyc();
      bus.step_req = 1'b0;
      total++;
      if (en_vec() !== 7'b1000000 || bus.halted !== 1'b0) begin
         bad++;
         $display("FAIL step_fetch: en=%b halted=%b want 1000000/0", en_vec(), bus.halted);
      end
      cyc();
      total++;
      if (en_vec() !== 7'b0100000) begin
         bad++;
         $display("FAIL step_exec: en=%b want 0100000", en_vec());
      end
      cyc();
      total++;
      if (en_vec() !== 7'b0011000) begin
         bad++;
         $display("FAIL step_wb: en=%b want 0011000", en_vec());
      end
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.step_ack !== 1'b1 || bus.retired !== 16'd1 ||
          en_vec() !== 7'b0) begin
         bad++;
         $display("FAIL step_done: halted=%b ack=%b retired=%0d en=%b want 1/1/1/0000000",
                  bus.halted, bus.step_ack, bus.retired, en_vec());
      end
      cyc();
      total++;
      if (bus.step_ack !== 1'b0 || bus.halted !== 1'b1 || bus.pc_value !== 8'd1) begin
         bad++;
         $display("FAIL step_ack_pulse: ack=%b halted=%b pc=%0d want 0/1/1",
                  bus.step_ack, bus.halted, bus.pc_value);
      end
      bus.dec_load  = 1'b0;
      bus.dec_store = 1'b0;
   endtask

   task automatic test_run_halt();
      do_reset();
      bus.run_req = 1'b1;
      cyc();
      for (int k = 0; k < 30; k++) begin
         total++;
         if (bus.pc_en !== ((k % 3) == 2) || bus.ir_we !== ((k % 3) == 0)) begin
            bad++;
            $display("FAIL run_cadence[%0d]: pc_en=%b ir_we=%b want %b/%b", k, bus.pc_en,
                     bus.ir_we, ((k % 3) == 2), ((k % 3) == 0));
         end
         cyc();
      end
      total++;
      if (bus.retired !== 16'd10 || bus.halted !== 1'b0) begin
         bad++;
         $display("FAIL run_retired: retired=%0d halted=%b want 10/0", bus.retired, bus.halted);
      end
      cyc();
      bus.halt_req = 1'b1;
      bus.run_req  = 1'b0;
      cyc();
      bus.halt_req = 1'b0;
      total++;
      if (bus.halted !== 1'b0 || bus.pc_en !== 1'b1) begin
         bad++;
         $display("FAIL halt_finishes_wb: halted=%b pc_en=%b want 0/1", bus.halted, bus.pc_en);
      end
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.retired !== 16'd11 || bus.step_ack !== 1'b0) begin
         bad++;
         $display("FAIL halt_done: halted=%b retired=%0d ack=%b want 1/11/0",
                  bus.halted, bus.retired, bus.step_ack);
      end
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.retired !== 16'd11) begin
         bad++;
         $display("FAIL halt_holds: halted=%b retired=%0d want 1/11", bus.halted, bus.retired);
      end
   endtask

   task automatic test_breakpoint();
      do_reset();
      bus.bp_en   = 1'b1;
      bus.bp_addr = 8'd5;
      bus.run_req = 1'b1;
      cyc();
      bus.run_req = 1'b0;
      repeat (15) cyc();
      total++;
      if (bus.ir_we !== 1'b0 || bus.halted !== 1'b0 || bus.pc_value !== 8'd5) begin
         bad++;
         $display("FAIL bp_fetch: ir_we=%b halted=%b pc=%0d want 0/0/5",
                  bus.ir_we, bus.halted, bus.pc_value);
      end
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.bp_hit !== 1'b1 || bus.retired !== 16'd5 ||
          en_vec() !== 7'b0) begin
         bad++;
         $display("FAIL bp_halt: halted=%b bp_hit=%b retired=%0d en=%b want 1/1/5/0000000",
                  bus.halted, bus.bp_hit, bus.retired, en_vec());
      end
      bus.run_req = 1'b1;
      cyc();
      bus.run_req = 1'b0;
      total++;
      if (bus.ir_we !== 1'b1 || bus.bp_hit !== 1'b0 || bus.halted !== 1'b0) begin
         bad++;
         $display("FAIL bp_resume: ir_we=%b bp_hit=%b halted=%b want 1/0/0",
                  bus.ir_we, bus.bp_hit, bus.halted);
      end
      repeat (3) cyc();
      total++;
      if (bus.halted !== 1'b0 || bus.retired !== 16'd6 || bus.pc_value !== 8'd6) begin
         bad++;
         $display("FAIL bp_no_rehit: halted=%b retired=%0d pc=%0d want 0/6/6",
                  bus.halted, bus.retired, bus.pc_value);
      end
   endtask

   task automatic test_flow_gating();
      logic [2:0] oh;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         oh = 3'b100 >> i;
         {bus.dec_jmp, bus.dec_cal, bus.dec_ret} = oh;
         bus.step_req = 1'b1;
         cyc();
         bus.step_req = 1'b0;
         total++;
         if (en_vec() !== 7'b1000000) begin
            bad++;
            $display("FAIL flow_fetch[%0d]: en=%b want 1000000", i, en_vec());
         end
         cyc();
         total++;
         if (en_vec() !== 7'b0000000) begin
            bad++;
            $display("FAIL flow_exec[%0d]: en=%b want 0000000", i, en_vec());
         end
         cyc();
         total++;
         if (en_vec() !== {4'b0001, oh}) begin
            bad++;
            $display("FAIL flow_wb[%0d]: en=%b want %b", i, en_vec(), {4'b0001, oh});
         end
         cyc();
         total++;
         if (bus.step_ack !== 1'b1 || bus.retired !== 16'(i + 1)) begin
            bad++;
            $display("FAIL flow_ack[%0d]: ack=%b retired=%0d want 1/%0d",
                     i, bus.step_ack, bus.retired, i + 1);
         end
         cyc();
      end
      {bus.dec_jmp, bus.dec_cal, bus.dec_ret} = 3'b000;
   endtask

   task automatic test_halt_step_collide();
      do_reset();
      bus.halt_req = 1'b1;
      bus.step_req = 1'b1;
      cyc();
      bus.halt_req = 1'b0;
      bus.step_req = 1'b0;
      total++;
      if (bus.halted !== 1'b1 || en_vec() !== 7'b0) begin
         bad++;
         $display("FAIL collide_hold: halted=%b en=%b want 1/0000000", bus.halted, en_vec());
      end
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.step_ack !== 1'b0 || bus.retired !== 16'd0) begin
         bad++;
         $display("FAIL collide_no_ack: halted=%b ack=%b retired=%0d want 1/0/0",
                  bus.halted, bus.step_ack, bus.retired);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.dec_load = 1'b1;
      bus.step_req = 1'b1;
      cyc();
      bus.step_req = 1'b0;
      cyc();
      total++;
      if (bus.acc_we !== 1'b1) begin
         bad++;
         $display("FAIL arst_pre: acc_we=%b want 1", bus.acc_we);
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (en_vec() !== 7'b0 || bus.halted !== 1'b1) begin
         bad++;
         $display("FAIL arst_drop: en=%b halted=%b want 0000000/1", en_vec(), bus.halted);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.dec_load = 1'b0;
      cyc();
      total++;
      if (bus.halted !== 1'b1 || bus.retired !== 16'd0 || en_vec() !== 7'b0) begin
         bad++;
         $display("FAIL arst_after: halted=%b retired=%0d en=%b want 1/0/0000000",
                  bus.halted, bus.retired, en_vec());
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_run_halt();
      test_breakpoint();
      test_flow_gating();
      test_halt_step_collide();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run-control sequencer for the accumulator core. It steps each instruction through FETCH, EXEC and WB, and gates the decoder's strobes (`load`, `store`, `jmp`, `cal_f`, `ret_f`) into one-cycle write/update enables for acc, reg_file, program_counter and call_reg. It also provides halt, single-step and breakpoint control for the bench or debug host, plus a retired-instruction counter. It sits between instruction_decoder and the stateful datapath blocks inside core.

## Interface
- `CNTR_WIDTH`, 8, program counter width (matches core).
- `RET_WIDTH`, 16, retired-instruction counter width.
- `START_RUNNING`, 0, 1 = leave reset in FETCH with run mode on; 0 = leave reset in HALT.

- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run_req`  in  1  level; while high and no halt pending, the sequencer free-runs.
- `halt_req`  in  1  one-cycle pulse; halts at the next instruction boundary.
- `step_req`  in  1  one-cycle pulse; executes exactly one instruction from HALT.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  CNTR_WIDTH  breakpoint PC value.
- `pc_value`  in  CNTR_WIDTH  current program_counter output.
- `dec_load`, `dec_store`, `dec_jmp`, `dec_cal`, `dec_ret`  in  1 each  raw decoder strobes.
- `ir_we`  out  1  latch instruction word (FETCH).
- `acc_we`  out  1  accumulator write (EXEC).
- `rf_we`  out  1  register-file write (WB).
- `pc_en`  out  1  PC advance/load (WB).
- `jmp_en`, `cal_en`, `ret_en`  out  1 each  gated control-flow strobes (WB).
- `halted`  out  1  state == HALT.
- `step_ack`  out  1  one-cycle pulse when a step completes.
- `bp_hit`  out  1  sticky; a breakpoint caused the current halt.
- `retired`  out  RET_WIDTH  instructions completed since reset.

## Operation
- States: HALT, FETCH, EXEC, WB. Every instruction takes exactly 3 cycles: FETCH → EXEC → WB.
- Outputs are Moore-decoded from state and gated by the decoder inputs:
  - `ir_we` = FETCH.
  - `acc_we` = EXEC & dec_load.
  - `rf_we` = WB & dec_store.
  - `pc_en` = WB.
  - `jmp_en` = WB & dec_jmp; `cal_en` = WB & dec_cal; `ret_en` = WB & dec_ret.
  - Every enable is 0 in HALT.
- Internal flags:
  - `run_mode`: set by run_req in HALT; cleared by halt_req or breakpoint.
  - `halt_pend`: set by a halt_req pulse in any non-HALT state; cleared on entering HALT.
  - `step_mode`: set by step_req taken in HALT; cleared on entering HALT.
  - `bp_skip`: set on every exit from HALT; cleared at the end of the first FETCH.
- HALT exit, evaluated each cycle in HALT:
  - Priority halt_req > step_req > run_req.
  - halt_req in HALT has no effect besides holding HALT.
  - step_req → FETCH with step_mode = 1.
  - run_req → FETCH with run_mode = 1.
  - Both exits clear bp_hit.
- FETCH breakpoint check:
  - Condition: bp_en & !bp_skip & pc_value == bp_addr.
  - If true: go to HALT instead of EXEC, set bp_hit, clear run_mode, and assert no ir_we in that cycle. Only the FETCH cycle's `ir_we` is suppressed.
- WB exit:
  - Increment `retired` (wraps modulo 2^RET_WIDTH).
  - If halt_pend | step_mode | !run_mode → HALT, else → FETCH.
  - `step_ack` pulses in the first HALT cycle after a step-mode WB.
- An instruction is never aborted once FETCH completes; halt_req only takes effect at the WB boundary.
- Reset (async): state = HALT (or FETCH if START_RUNNING), run_mode = START_RUNNING, all flags 0, retired = 0, bp_hit = 0, step_ack = 0, all enables 0.

## Timing
- Free-run throughput: 1 instruction per 3 cycles.
- HALT → FETCH takes one cycle after run_req/step_req is sampled.
- step_req sampled in cycle t gives: FETCH t+1, EXEC t+2, WB t+3, HALT with step_ack = 1 at t+4.
- halt_req sampled during FETCH/EXEC/WB: the current instruction retires, then HALT. If sampled in WB, HALT is entered next cycle.
- Simultaneous halt_req and step_req in HALT: stays halted, no step_ack.
- Breakpoint at the resume address: the first FETCH after leaving HALT is not checked (bp_skip). This prevents a re-hit loop.
- rst asserted mid-instruction: all enables drop in the same cycle (asynchronous); no partial write is issued after assertion.

## Test plan
- Reset with START_RUNNING=0, run_req=0 → halted=1, all enables 0, retired=0 for 10 cycles.
- Pulse step_req once, decoder load=1 and store=1 → ir_we at t+1, acc_we at t+2, rf_we/pc_en at t+3, step_ack at t+4, retired=1, halted=1.
- Hold run_req=1 for 30 cycles → retired=10, pc_en high every 3rd cycle; then pulse halt_req during EXEC → that instruction retires (retired=11), then halted=1.
- bp_en=1, bp_addr=5, run with PC incrementing from 0 → halt in FETCH with pc_value=5, bp_hit=1, retired=5; then run_req → the instruction at 5 executes, bp_hit clears, no immediate re-halt.
- dec_jmp=1 only during WB, dec_jmp=1 held during FETCH/EXEC → jmp_en asserted only in the WB cycle; dec_cal/dec_ret behave the same.
- Assert rst in the EXEC cycle with dec_load=1 → acc_we drops immediately; after release the sequencer is halted, retired=0.
